// File: rtl/control_pipeline_regs_if.sv
// Control bundle between decoder/datapath and the pipeline control registers:
// ID-stage fields and hazard inputs in, per-stage EX/MEM/WB controls out.
interface control_pipeline_regs_if #(
  parameter int RD_W     = 5,
  parameter int ALU_FN_W = 3
);
  logic                stall_d;
  logic                reg_write_d;
  logic [1:0]          result_src_d;
  logic                mem_write_d;
  logic                alu_src_d;
  logic [ALU_FN_W-1:0] alu_function_d;
  logic                beq_d;
  logic                bne_d;
  logic                jump_d;
  logic                jalr_d;
  logic [RD_W-1:0]     rd_d;
  logic                zero_e;

  logic                alu_src_e;
  logic [ALU_FN_W-1:0] alu_function_e;
  logic [1:0]          pc_src_e;
  logic                flush_d;
  logic                result_src_e_load;
  logic [RD_W-1:0]     rd_e;
  logic                reg_write_m;
  logic                mem_write_m;
  logic [1:0]          result_src_m;
  logic [RD_W-1:0]     rd_m;
  logic                reg_write_w;
  logic [1:0]          result_src_w;
  logic [RD_W-1:0]     rd_w;

  modport master (
    output stall_d, reg_write_d, result_src_d, mem_write_d, alu_src_d,
           alu_function_d, beq_d, bne_d, jump_d, jalr_d, rd_d, zero_e,
    input  alu_src_e, alu_function_e, pc_src_e, flush_d, result_src_e_load,
           rd_e, reg_write_m, mem_write_m, result_src_m, rd_m,
           reg_write_w, result_src_w, rd_w
  );

  modport slave (
    input  stall_d, reg_write_d, result_src_d, mem_write_d, alu_src_d,
           alu_function_d, beq_d, bne_d, jump_d, jalr_d, rd_d, zero_e,
    output alu_src_e, alu_function_e, pc_src_e, flush_d, result_src_e_load,
           rd_e, reg_write_m, mem_write_m, result_src_m, rd_m,
           reg_write_w, result_src_w, rd_w
  );
endinterface

// File: rtl/control_pipeline_regs.sv
// ID/EX, EX/MEM, MEM/WB control registers with branch/jump resolution in EX.
// Latency: ID->EX 1, ->MEM 2, ->WB 3 cycles; pc_src_e/flush_d combinational from EX.
// No backpressure: stall or taken transfer loads a bubble into EX, later stages always advance.
module control_pipeline_regs #(
  parameter int RD_W     = 5,
  parameter int ALU_FN_W = 3
) (
  input logic                   clk,
  input logic                   rst,
  control_pipeline_regs_if.slave bus
);

  typedef struct packed {
    logic                reg_write;
    logic [1:0]          result_src;
    logic                mem_write;
    logic                alu_src;
    logic [ALU_FN_W-1:0] alu_function;
    logic                beq;
    logic                bne;
    logic                jump;
    logic                jalr;
    logic [RD_W-1:0]     rd;
  } ex_t;

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
    logic [RD_W-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic [RD_W-1:0] rd;
  } wb_t;

  ex_t  ex_q, ex_nxt;
  mem_t mem_q;
  wb_t  wb_q;
  logic taken_e;
  logic bubble;

  // beq and bne together evaluate as an OR, i.e. always taken
  always_comb begin
    taken_e = ex_q.jump | ex_q.jalr
            | (ex_q.beq & bus.zero_e)
            | (ex_q.bne & ~bus.zero_e);
    bubble  = bus.stall_d | taken_e;

    ex_nxt = '0;
    if (!bubble) begin
      ex_nxt.reg_write    = bus.reg_write_d & (bus.rd_d != '0);
      ex_nxt.result_src   = bus.result_src_d;
      ex_nxt.mem_write    = bus.mem_write_d;
      ex_nxt.alu_src      = bus.alu_src_d;
      ex_nxt.alu_function = bus.alu_function_d;
      ex_nxt.beq          = bus.beq_d;
      ex_nxt.bne          = bus.bne_d;
      ex_nxt.jump         = bus.jump_d;
      ex_nxt.jalr         = bus.jalr_d;
      ex_nxt.rd           = bus.rd_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q             <= ex_nxt;
      mem_q.reg_write  <= ex_q.reg_write;
      mem_q.mem_write  <= ex_q.mem_write;
      mem_q.result_src <= ex_q.result_src;
      mem_q.rd         <= ex_q.rd;
      wb_q.reg_write   <= mem_q.reg_write;
      wb_q.result_src  <= mem_q.result_src;
      wb_q.rd          <= mem_q.rd;
    end
  end

  assign bus.pc_src_e          = ex_q.jalr ? 2'b10 : (taken_e ? 2'b01 : 2'b00);
  assign bus.flush_d           = taken_e;
  assign bus.alu_src_e         = ex_q.alu_src;
  assign bus.alu_function_e    = ex_q.alu_function;
  assign bus.result_src_e_load = (ex_q.result_src == 2'b01);
  assign bus.rd_e              = ex_q.rd;
  assign bus.reg_write_m       = mem_q.reg_write;
  assign bus.mem_write_m       = mem_q.mem_write;
  assign bus.result_src_m      = mem_q.result_src;
  assign bus.rd_m              = mem_q.rd;
  assign bus.reg_write_w       = wb_q.reg_write;
  assign bus.result_src_w      = wb_q.result_src;
  assign bus.rd_w              = wb_q.rd;

endmodule

// File: tb/tb_control_pipeline_regs.sv
// Directed-vector bench for control_pipeline_regs: flow, branches, jalr, stall, x0, reset.
module tb_control_pipeline_regs;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  control_pipeline_regs_if #(.RD_W(5), .ALU_FN_W(3)) bus ();

  control_pipeline_regs #(.RD_W(5), .ALU_FN_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.stall_d        = 1'b0;
    bus.reg_write_d    = 1'b0;
    bus.result_src_d   = 2'b00;
    bus.mem_write_d    = 1'b0;
    bus.alu_src_d      = 1'b0;
    bus.alu_function_d = 3'b000;
    bus.beq_d          = 1'b0;
    bus.bne_d          = 1'b0;
    bus.jump_d         = 1'b0;
    bus.jalr_d         = 1'b0;
    bus.rd_d           = 5'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.zero_e = 1'b0;
    bus.reg_write_d    = 1'b1;
    bus.rd_d           = 5'd7;
    bus.alu_function_d = 3'b101;
    bus.result_src_d   = 2'b01;
    #12;
    chk("rst_init_rd_e", bus.rd_e, 0);
    chk("rst_init_pc_src", bus.pc_src_e, 0);
    rst = 1'b0;

    // Fill the pipe, then reset asynchronously between edges
    repeat (3) step();
    chk("fill_rd_w", bus.rd_w, 7);
    #2 rst = 1'b1;
    #1;
    chk("arst_alu_fn_e", bus.alu_function_e, 0);
    chk("arst_rd_e", bus.rd_e, 0);
    chk("arst_rd_m", bus.rd_m, 0);
    chk("arst_rd_w", bus.rd_w, 0);
    chk("arst_reg_write_w", bus.reg_write_w, 0);
    chk("arst_flush", bus.flush_d, 0);
    rst = 1'b0;
    idle();
    step();

    // Add-type flow through all stages
    bus.reg_write_d = 1'b1; bus.rd_d = 5'd5; bus.alu_function_d = 3'b010; bus.alu_src_d = 1'b1;
    step(); idle();
    chk("add_alu_fn_e", bus.alu_function_e, 3'b010);
    chk("add_alu_src_e", bus.alu_src_e, 1);
    chk("add_rd_e", bus.rd_e, 5);
    step();
    chk("add_rd_m", bus.rd_m, 5);
    chk("add_reg_write_m", bus.reg_write_m, 1);
    step();
    chk("add_reg_write_w", bus.reg_write_w, 1);
    chk("add_rd_w", bus.rd_w, 5);
    chk("add_result_src_w", bus.result_src_w, 0);

    // beq taken: following instruction is bubbled
    bus.beq_d = 1'b1;
    step(); idle();
    bus.rd_d = 5'd9; bus.alu_function_d = 3'b011; bus.reg_write_d = 1'b1;
    bus.zero_e = 1'b1;
    #1;
    chk("beq_t_pc_src", bus.pc_src_e, 2'b01);
    chk("beq_t_flush", bus.flush_d, 1);
    step();
    chk("beq_t_bubble_rd_e", bus.rd_e, 0);
    chk("beq_t_bubble_alu", bus.alu_function_e, 0);
    chk("beq_t_bubble_pc_src", bus.pc_src_e, 0);
    idle(); bus.zero_e = 1'b0;

    // beq not taken: no bubble
    bus.beq_d = 1'b1;
    step(); idle();
    bus.rd_d = 5'd9; bus.alu_function_d = 3'b110;
    #1;
    chk("beq_nt_pc_src", bus.pc_src_e, 0);
    chk("beq_nt_flush", bus.flush_d, 0);
    step();
    chk("beq_nt_rd_e", bus.rd_e, 9);
    chk("beq_nt_alu", bus.alu_function_e, 3'b110);
    idle();

    // bne taken on zero_e=0
    bus.bne_d = 1'b1;
    step(); idle();
    #1;
    chk("bne_pc_src", bus.pc_src_e, 2'b01);
    chk("bne_flush", bus.flush_d, 1);
    step();

    // jalr redirects and still writes back its link register
    bus.jalr_d = 1'b1; bus.rd_d = 5'd1; bus.result_src_d = 2'b10; bus.reg_write_d = 1'b1;
    step(); idle();
    chk("jalr_pc_src", bus.pc_src_e, 2'b10);
    chk("jalr_flush", bus.flush_d, 1);
    step(); step();
    chk("jalr_reg_write_w", bus.reg_write_w, 1);
    chk("jalr_rd_w", bus.rd_w, 1);
    chk("jalr_result_src_w", bus.result_src_w, 2'b10);

    // Load-use stall: one bubble, load proceeds
    bus.reg_write_d = 1'b1; bus.result_src_d = 2'b01; bus.rd_d = 5'd3;
    step(); idle();
    chk("load_e_flag", bus.result_src_e_load, 1);
    bus.reg_write_d = 1'b1; bus.rd_d = 5'd4; bus.alu_function_d = 3'b001; bus.stall_d = 1'b1;
    step();
    chk("stall_bubble_rd_e", bus.rd_e, 0);
    chk("stall_bubble_alu", bus.alu_function_e, 0);
    chk("stall_load_src_m", bus.result_src_m, 2'b01);
    chk("stall_load_rd_m", bus.rd_m, 3);
    bus.stall_d = 1'b0;
    step();
    chk("stall_reissue_rd_e", bus.rd_e, 4);
    idle();

    // x0 write dropped at ID/EX
    bus.reg_write_d = 1'b1; bus.rd_d = 5'd0; bus.alu_function_d = 3'b111;
    step(); idle();
    chk("x0_alu_fn_e", bus.alu_function_e, 3'b111);
    step();
    chk("x0_reg_write_m", bus.reg_write_m, 0);

    // Stall together with taken jump: single bubble, flush wins
    bus.jump_d = 1'b1;
    step(); idle();
    bus.rd_d = 5'd6; bus.alu_function_d = 3'b100; bus.stall_d = 1'b1;
    #1;
    chk("st_tk_flush", bus.flush_d, 1);
    chk("st_tk_pc_src", bus.pc_src_e, 2'b01);
    step();
    chk("st_tk_bubble_rd_e", bus.rd_e, 0);
    chk("st_tk_flush_after", bus.flush_d, 0);
    bus.stall_d = 1'b0;
    step();
    chk("st_tk_next_rd_e", bus.rd_e, 6);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
